// File: rtl/mem_port_arbiter.sv
// Shares the external memory port between the CPU and a host loader/debug port.
// Latency: CPU passthrough is combinational; a host access completes 5 cycles after host_req once the CPU acks the hold.
// Backpressure: host waits (level host_req) until the CPU stalls; the request is aborted with host_err after ACK_TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int AW          = 16,
  parameter int DW          = 8,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] cpu_bus,
  input  logic          cpu_mar_we,
  input  logic          cpu_ram_we,
  input  logic          cpu_ack,
  output logic          cpu_hold,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_err,
  output logic [DW-1:0] host_rdata,
  input  logic [DW-1:0] mem_out,
  output logic [AW-1:0] mem_bus,
  output logic          mem_mar_we,
  output logic          mem_ram_we,
  output logic          busy
);

  // Counter only needs to reach ACK_TIMEOUT-1.
  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ACK,
    H_ADDR,
    H_DATA,
    RESTORE,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [AW-1:0] shadow_mar;
  logic [CW-1:0] wait_cnt;
  logic          err_flag;
  logic          passthru;
  logic          timeout_hit;

  assign passthru    = (state == IDLE) || (state == WAIT_ACK);
  // ACK_TIMEOUT of zero disables the abort path entirely.
  assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_cnt == CW'(ACK_TIMEOUT - 1));

  assign busy     = (state != IDLE);
  assign cpu_hold = busy;
  assign host_gnt = (state == DONE);
  assign host_err = (state == DONE) && err_flag;

  // Next-state and memory-port drive; the host sequence owns the port outside IDLE/WAIT_ACK.
  always_comb begin
    state_nxt  = state;
    mem_bus    = '0;
    mem_mar_we = 1'b0;
    mem_ram_we = 1'b0;
    case (state)
      IDLE: begin
        mem_bus    = cpu_bus;
        mem_mar_we = cpu_mar_we;
        mem_ram_we = cpu_ram_we;
        if (host_req) state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        mem_bus    = cpu_bus;
        mem_mar_we = cpu_mar_we;
        mem_ram_we = cpu_ram_we;
        if (cpu_ack)          state_nxt = H_ADDR;
        else if (timeout_hit) state_nxt = DONE;
      end
      H_ADDR: begin
        mem_bus    = host_addr;
        mem_mar_we = 1'b1;
        state_nxt  = H_DATA;
      end
      H_DATA: begin
        if (host_we) begin
          mem_bus    = AW'(host_wdata);
          mem_ram_we = 1'b1;
        end
        state_nxt = RESTORE;
      end
      RESTORE: begin
        // Put the CPU's MAR back so it resumes exactly where it stalled.
        mem_bus    = shadow_mar;
        mem_mar_we = 1'b1;
        state_nxt  = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, wait counter, abort flag, shadow MAR and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow_mar <= '0;
      wait_cnt   <= '0;
      err_flag   <= 1'b0;
      host_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (passthru && cpu_mar_we) shadow_mar <= cpu_bus;
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (state == WAIT_ACK && !cpu_ack) begin
        if (timeout_hit) err_flag <= 1'b1;
        else             wait_cnt <= wait_cnt + CW'(1);
      end
      if (state == DONE) err_flag <= 1'b0;
      if (state == H_DATA && !host_we) host_rdata <= mem_out;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed per-cycle vector bench for mem_port_arbiter with a small MAR/RAM memory model.
// Each vector is driven 1ns after a rising edge and checked at the following falling edge.
// Host transactions, timeout abort, back-to-back and mid-transaction reset are covered.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_bus;
  logic        cpu_mar_we;
  logic        cpu_ram_we;
  logic        cpu_ack;
  logic        cpu_hold;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_gnt;
  logic        host_err;
  logic [7:0]  host_rdata;
  logic [7:0]  mem_out;
  logic [15:0] mem_bus;
  logic        mem_mar_we;
  logic        mem_ram_we;
  logic        busy;

  mem_port_arbiter #(.AW(16), .DW(8), .ACK_TIMEOUT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_bus    (cpu_bus),
    .cpu_mar_we (cpu_mar_we),
    .cpu_ram_we (cpu_ram_we),
    .cpu_ack    (cpu_ack),
    .cpu_hold   (cpu_hold),
    .host_req   (host_req),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_gnt   (host_gnt),
    .host_err   (host_err),
    .host_rdata (host_rdata),
    .mem_out    (mem_out),
    .mem_bus    (mem_bus),
    .mem_mar_we (mem_mar_we),
    .mem_ram_we (mem_ram_we),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: MAR register plus RAM addressed by the low MAR bits.
  logic [7:0]  ram [0:1023];
  logic [15:0] mar;
  logic        load_en;
  logic [9:0]  load_a;
  logic [7:0]  load_d;

  always @(posedge clk) begin
    if (load_en) ram[load_a] <= load_d;
    if (rst) mar <= 16'h0000;
    else if (mem_mar_we) mar <= mem_bus;
    if (mem_ram_we) ram[mar[9:0]] <= mem_bus[7:0];
  end
  assign mem_out = ram[mar[9:0]];

  typedef struct {
    logic        rst;
    logic [15:0] bus;
    logic        mwe, rwe, ack, req, we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [15:0] ebus;
    logic        emwe, erwe, ehold, egnt, eerr;
    logic [7:0]  erd;
  } vec_t;

  function automatic vec_t v(input logic r, input logic [15:0] b, input logic mw, input logic rw,
                             input logic a, input logic rq, input logic w, input logic [15:0] ad,
                             input logic [7:0] d, input logic [15:0] eb, input logic emw,
                             input logic erw, input logic eh, input logic eg, input logic ee,
                             input logic [7:0] erd);
    vec_t t;
    t.rst = r; t.bus = b; t.mwe = mw; t.rwe = rw; t.ack = a; t.req = rq; t.we = w;
    t.addr = ad; t.wd = d; t.ebus = eb; t.emwe = emw; t.erwe = erw; t.ehold = eh;
    t.egnt = eg; t.eerr = ee; t.erd = erd;
    return t;
  endfunction

  int n_cmp;
  int n_bad;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // One cycle: drive after the rising edge, check at the falling edge.
  task automatic run(input vec_t t, input int idx);
    @(posedge clk);
    #1;
    rst        = t.rst;
    cpu_bus    = t.bus;
    cpu_mar_we = t.mwe;
    cpu_ram_we = t.rwe;
    cpu_ack    = t.ack;
    host_req   = t.req;
    host_we    = t.we;
    host_addr  = t.addr;
    host_wdata = t.wd;
    #4;
    chk("mem_bus",    idx, mem_bus,            t.ebus);
    chk("mem_mar_we", idx, {15'd0, mem_mar_we}, {15'd0, t.emwe});
    chk("mem_ram_we", idx, {15'd0, mem_ram_we}, {15'd0, t.erwe});
    chk("cpu_hold",   idx, {15'd0, cpu_hold},   {15'd0, t.ehold});
    chk("host_gnt",   idx, {15'd0, host_gnt},   {15'd0, t.egnt});
    chk("host_err",   idx, {15'd0, host_err},   {15'd0, t.eerr});
    chk("host_rdata", idx, {8'd0, host_rdata},  {8'd0, t.erd});
  endtask

  vec_t tbl [37];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //            rst bus     mwe rwe ack req we addr     wd      ebus    emw erw hld gnt err rd
    tbl[0]  = v(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h00);
    // CPU passthrough sets shadow to 1234
    tbl[1]  = v(0, 16'h1234, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h1234, 1, 0, 0, 0, 0, 8'h00);
    // Host read of 0x0100 with CPU strobes pulsed during the host phases
    tbl[2]  = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h00);
    tbl[3]  = v(0, 16'h0000, 0, 0, 1, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 8'h00);
    tbl[4]  = v(0, 16'hFFFF, 1, 1, 0, 1, 0, 16'h0100, 8'h00, 16'h0100, 1, 0, 1, 0, 0, 8'h00);
    tbl[5]  = v(0, 16'hFFFF, 1, 1, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 8'h00);
    tbl[6]  = v(0, 16'hFFFF, 1, 1, 0, 1, 0, 16'h0100, 8'h00, 16'h1234, 1, 0, 1, 0, 0, 8'h5A);
    tbl[7]  = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 1, 0, 8'h5A);
    tbl[8]  = v(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h5A);
    // Shadow to 0040, then host write A5 to 0x0100
    tbl[9]  = v(0, 16'h0040, 1, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0040, 1, 0, 0, 0, 0, 8'h5A);
    tbl[10] = v(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'hA5, 16'h0000, 0, 0, 0, 0, 0, 8'h5A);
    tbl[11] = v(0, 16'h0000, 0, 0, 1, 1, 1, 16'h0100, 8'hA5, 16'h0000, 0, 0, 1, 0, 0, 8'h5A);
    tbl[12] = v(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'hA5, 16'h0100, 1, 0, 1, 0, 0, 8'h5A);
    tbl[13] = v(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'hA5, 16'h00A5, 0, 1, 1, 0, 0, 8'h5A);
    tbl[14] = v(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'hA5, 16'h0040, 1, 0, 1, 0, 0, 8'h5A);
    tbl[15] = v(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'hA5, 16'h0000, 0, 0, 1, 1, 0, 8'h5A);
    tbl[16] = v(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h5A);
    // Timeout abort with cpu_ack held low; CPU MAR write still forwarded in WAIT_ACK
    tbl[17] = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h5A);
    tbl[18] = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 8'h5A);
    tbl[19] = v(0, 16'h0040, 1, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0040, 1, 0, 1, 0, 0, 8'h5A);
    tbl[20] = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 8'h5A);
    tbl[21] = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 8'h5A);
    tbl[22] = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 1, 1, 8'h5A);
    tbl[23] = v(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h5A);
    // Back-to-back: write 3C then read it back; MAR write on the request cycle is shadowed
    tbl[24] = v(0, 16'h0077, 1, 0, 0, 1, 1, 16'h0100, 8'h3C, 16'h0077, 1, 0, 0, 0, 0, 8'h5A);
    tbl[25] = v(0, 16'h0000, 0, 0, 1, 1, 1, 16'h0100, 8'h3C, 16'h0000, 0, 0, 1, 0, 0, 8'h5A);
    tbl[26] = v(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'h3C, 16'h0100, 1, 0, 1, 0, 0, 8'h5A);
    tbl[27] = v(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'h3C, 16'h003C, 0, 1, 1, 0, 0, 8'h5A);
    tbl[28] = v(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'h3C, 16'h0077, 1, 0, 1, 0, 0, 8'h5A);
    tbl[29] = v(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'h3C, 16'h0000, 0, 0, 1, 1, 0, 8'h5A);
    tbl[30] = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h5A);
    tbl[31] = v(0, 16'h0000, 0, 0, 1, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 8'h5A);
    tbl[32] = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0100, 1, 0, 1, 0, 0, 8'h5A);
    tbl[33] = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 8'h5A);
    tbl[34] = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0077, 1, 0, 1, 0, 0, 8'h3C);
    tbl[35] = v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 1, 0, 8'h3C);
    tbl[36] = v(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h3C);

    // Reset and preload ram[0x100] = 5A
    rst = 1'b1; cpu_bus = '0; cpu_mar_we = 0; cpu_ram_we = 0; cpu_ack = 0;
    host_req = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    load_en = 1'b1; load_a = 10'h100; load_d = 8'h5A;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    load_en = 1'b0;

    for (int i = 0; i < 37; i++) run(tbl[i], i);

    // Reset asserted in H_DATA of a write: next cycle IDLE, no grant, shadow and rdata cleared
    run(v(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'h99, 16'h0000, 0, 0, 0, 0, 0, 8'h3C), 100);
    run(v(0, 16'h0000, 0, 0, 1, 1, 1, 16'h0100, 8'h99, 16'h0000, 0, 0, 1, 0, 0, 8'h3C), 101);
    run(v(0, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'h99, 16'h0100, 1, 0, 1, 0, 0, 8'h3C), 102);
    run(v(1, 16'h0000, 0, 0, 0, 1, 1, 16'h0100, 8'h99, 16'h0099, 0, 1, 1, 0, 0, 8'h3C), 103);
    run(v(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h00), 104);
    run(v(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h00), 105);
    // Follow-up read shows the write landed and the restore uses the cleared shadow
    run(v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h00), 106);
    run(v(0, 16'h0000, 0, 0, 1, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 8'h00), 107);
    run(v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0100, 1, 0, 1, 0, 0, 8'h00), 108);
    run(v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 0, 0, 8'h00), 109);
    run(v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 1, 0, 1, 0, 0, 8'h99), 110);
    run(v(0, 16'h0000, 0, 0, 0, 1, 0, 16'h0100, 8'h00, 16'h0000, 0, 0, 1, 1, 0, 8'h99), 111);
    run(v(0, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 8'h99), 112);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
